// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I size codes
// and the request legality helpers used at acceptance.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return |lane;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load value from a memory
// word, and merges sub-word store data into a memory word (little-endian).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B:    store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit: loads take one read cycle, sub-word stores
// do read-modify-write, illegal requests answer with an error and no access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_WORDS = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        WE,
  output logic [31:0] A_DM,
  output logic [31:0] WD,
  input  logic [31:0] RD3
);

  state_t      state, state_nxt;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept  = req_valid && req_ready;
  assign req_bad = f3_illegal(req_store, req_funct3)
                || misaligned(req_funct3, req_addr[1:0])
                || ({2'b00, req_addr[31:2]} >= 32'(DM_WORDS));

  lsu_align u_align (
    .word       (RD3),
    .lane       (addr_q[1:0]),
    .funct3     (f3_q),
    .wdata      (wd_q),
    .load_data  (load_data),
    .store_word (merged)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                  state_nxt = RSP;
          else if (!req_store)          state_nxt = RD;
          else if (req_funct3 == F3_W)  state_nxt = WR;
          else                          state_nxt = RD;
        end
      end
      RD:      state_nxt = st_q ? WR : RSP;
      WR:      state_nxt = RSP;
      RSP:     if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-facing outputs read as zero while idle so the bus is quiet between requests.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RSP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    WE         = (state == WR) && !RST;
    A_DM       = (state == IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
    WD         = (state == IDLE) ? 32'h0 : wd_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            st_q    <= req_store;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wd_q    <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= req_bad;
          end
        end
        RD: begin
          if (st_q) wd_q    <= merged;
          else      rdata_q <= load_data;
        end
        RSP: begin
          if (resp_ready) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single requests against a
// small memory model, plus backpressure and reset-during-write sequences.
module tb_load_store_unit;

  localparam int DM = 32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        WE;
  logic [31:0] A_DM, WD, RD3;

  logic [31:0] mem [DM] = '{0: 32'h1234_80FF, 3: 32'hAABB_CCDD, 31: 32'h7F00_0000, default: 32'h0};

  int checks = 0;
  int failures = 0;
  int we_total = 0;
  logic [31:0] last_wd = 32'h0;

  always #5 CLK = ~CLK;

  load_store_unit #(.DM_WORDS(DM)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .WE(WE), .A_DM(A_DM), .WD(WD), .RD3(RD3)
  );

  assign RD3 = (A_DM < DM) ? mem[A_DM[4:0]] : 32'h0;

  always @(posedge CLK) if (WE) mem[A_DM[4:0]] <= WD;

  always @(negedge CLK) begin
    if (WE) begin
      we_total <= we_total + 1;
      last_wd  <= WD;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_wd;
    int          mem_idx;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [18];

  // Presents one request at the negedge; returns once it has been accepted.
  task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge CLK);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts cycles from the accepting cycle until resp_valid, bounded.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string name);
    resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    resp_ready = 1'b0;
    check({name, "_valid_drop"}, {31'h0, resp_valid}, 32'h0);
    check({name, "_ready_back"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    int lat;
    int we0;
    logic [31:0] held;

    vecs[0]  = '{"lb_0",     1'b0, 3'b000, 32'h00, 32'h0,         32'hFFFF_FFFF, 1'b0, 2, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[1]  = '{"lbu_1",    1'b0, 3'b100, 32'h01, 32'h0,         32'h0000_0080, 1'b0, 2, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[2]  = '{"lh_2",     1'b0, 3'b001, 32'h02, 32'h0,         32'h0000_1234, 1'b0, 2, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[3]  = '{"lhu_0",    1'b0, 3'b101, 32'h00, 32'h0,         32'h0000_80FF, 1'b0, 2, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[4]  = '{"lh_0",     1'b0, 3'b001, 32'h00, 32'h0,         32'hFFFF_80FF, 1'b0, 2, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[5]  = '{"lw_0",     1'b0, 3'b010, 32'h00, 32'h0,         32'h1234_80FF, 1'b0, 2, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[6]  = '{"sb_d",     1'b1, 3'b000, 32'h0D, 32'h0000_0011, 32'h0,         1'b0, 3, 1, 32'hAABB_11DD, 3,  32'hAABB_11DD};
    vecs[7]  = '{"sw_10",    1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1, 32'hDEAD_BEEF, 4,  32'hDEAD_BEEF};
    vecs[8]  = '{"sh_12",    1'b1, 3'b001, 32'h12, 32'hFFFF_5566, 32'h0,         1'b0, 3, 1, 32'h5566_BEEF, 4,  32'h5566_BEEF};
    vecs[9]  = '{"lb_13",    1'b0, 3'b000, 32'h13, 32'h0,         32'h0000_0055, 1'b0, 2, 0, 32'h0,         4,  32'h5566_BEEF};
    vecs[10] = '{"lh_10",    1'b0, 3'b001, 32'h10, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 0, 32'h0,         4,  32'h5566_BEEF};
    vecs[11] = '{"lb_7f",    1'b0, 3'b000, 32'h7F, 32'h0,         32'h0000_007F, 1'b0, 2, 0, 32'h0,         31, 32'h7F00_0000};
    vecs[12] = '{"lbu_d",    1'b0, 3'b100, 32'h0D, 32'h0,         32'h0000_0011, 1'b0, 2, 0, 32'h0,         3,  32'hAABB_11DD};
    vecs[13] = '{"sw_6_mis", 1'b1, 3'b010, 32'h06, 32'h1234_5678, 32'h0,         1'b1, 1, 0, 32'h0,         1,  32'h0};
    vecs[14] = '{"lh_3_mis", 1'b0, 3'b001, 32'h03, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[15] = '{"lw_oor",   1'b0, 3'b010, 32'h80, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[16] = '{"ld_f3_3",  1'b0, 3'b011, 32'h00, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0,         0,  32'h1234_80FF};
    vecs[17] = '{"st_f3_4",  1'b1, 3'b100, 32'h00, 32'h0000_00AB, 32'h0,         1'b1, 1, 0, 32'h0,         0,  32'h1234_80FF};

    RST = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ready",  {31'h0, req_ready},  32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata",      resp_rdata,          32'h0);
    check("rst_err",        {31'h0, resp_err},   32'h0);
    check("rst_we",         {31'h0, WE},         32'h0);
    check("rst_a_dm",       A_DM,                32'h0);
    check("rst_wd",         WD,                  32'h0);
    RST = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      check({vecs[i].name, "_req_ready"}, {31'h0, req_ready}, 32'h1);
      we0 = we_total;
      present(vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      wait_resp(lat);
      check({vecs[i].name, "_lat"},   lat,                       vecs[i].exp_lat);
      check({vecs[i].name, "_rdata"}, resp_rdata,                vecs[i].exp_rdata);
      check({vecs[i].name, "_err"},   {31'h0, resp_err},         {31'h0, vecs[i].exp_err});
      handshake(vecs[i].name);
      check({vecs[i].name, "_we_cnt"}, we_total - we0,           vecs[i].exp_we);
      if (vecs[i].exp_we != 0)
        check({vecs[i].name, "_wd"}, last_wd, vecs[i].exp_wd);
      check({vecs[i].name, "_mem"}, mem[vecs[i].mem_idx], vecs[i].exp_mem);
    end

    // Backpressure: response held five cycles while a second request waits.
    present(1'b0, 3'b010, 32'h00, 32'h0);
    wait_resp(lat);
    check("bp_lat", lat, 2);
    held = resp_rdata;
    check("bp_rdata", held, 32'h1234_80FF);
    @(negedge CLK);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      check("bp_valid_held", {31'h0, resp_valid}, 32'h1);
      check("bp_rdata_held", resp_rdata, held);
      check("bp_ready_low",  {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    resp_ready = 1'b0;
    check("bp_hs_valid", {31'h0, resp_valid}, 32'h0);
    check("bp_hs_ready", {31'h0, req_ready},  32'h1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    wait_resp(lat);
    check("bp2_lat",   lat,        2);
    check("bp2_rdata", resp_rdata, 32'h5566_BEEF);
    handshake("bp2");

    // Reset asserted while the half-word store sits in WR.
    we0 = we_total;
    present(1'b1, 3'b001, 32'h00, 32'h0000_9999);
    @(posedge CLK);
    #1;
    check("rw_in_wr_we", {31'h0, WE}, 32'h1);
    RST = 1'b1;
    #1;
    check("rw_we_gated", {31'h0, WE}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rw_req_ready",  {31'h0, req_ready},  32'h1);
    check("rw_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rw_a_dm",       A_DM,                32'h0);
    check("rw_wd",         WD,                  32'h0);
    repeat (3) @(posedge CLK);
    #1;
    check("rw_no_resp", {31'h0, resp_valid}, 32'h0);
    check("rw_we_cnt",  we_total - we0,      0);
    check("rw_mem0",    mem[0],              32'h1234_80FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DM_WORDS, default 32: number of 32-bit words in the attached data memory; word index range 0..DM_WORDS-1.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  core accepts the response.
REQ-012 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned, illegal funct3, or out-of-range access.
REQ-014 WE  output  1  data-memory write enable.
REQ-015 A_DM  output  32  data-memory word index (req_addr[31:2], zero-extended).
REQ-016 WD  output  32  data-memory write word.
REQ-017 RD3  input  32  data-memory combinational read word for A_DM.

Function
REQ-018 FSM states: IDLE, RD, WR, RSP; req_ready SHALL be 1 only in IDLE.
REQ-019 Request accepted when req_valid & req_ready; the unit latches store, funct3, addr and wdata on acceptance.
REQ-020 Error check at acceptance: H/HU with addr[0]≠0, W with addr[1:0]≠0, funct3 not in {000,001,010,100,101} (stores: not in {000,001,010}), or addr[31:2] ≥ DM_WORDS -> IDLE→RSP, resp_err=1, no memory access.
REQ-021 Load: IDLE→RD→RSP; in RD, A_DM drives the latched word index and RD3 is captured; resp_valid asserts 2 cycles after acceptance.
REQ-022 Word store: IDLE→WR→RSP; WE=1 for exactly one cycle in WR with WD=req_wdata.
REQ-023 Byte/half store: IDLE→RD→WR→RSP (read-modify-write); WD equals the captured RD3 with only the addressed lane(s) replaced by the low 8/16 bits of req_wdata.
REQ-024 Lane select: byte lane = addr[1:0], half lane = addr[1]; little-endian.
REQ-025 Load extension: B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
REQ-026 RSP: resp_valid=1 with stable resp_rdata/resp_err until resp_valid & resp_ready, then →IDLE; no new request is accepted in that same cycle.
REQ-027 WE SHALL be 0 in every state except WR; A_DM and WD hold their latched values outside IDLE, and are 0 in IDLE.
REQ-028 WE is gated by !RST combinationally: no memory write occurs on a cycle where RST=1, including RST asserted while in WR.

Reset
REQ-029 On RST=1 at a rising edge: state→IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched request cleared; any in-flight request is dropped without a response.
REQ-030 After reset, req_ready=1, WE=0, A_DM=0, WD=0.

Structure
REQ-031 Shared package lsu_pkg holds the state enum and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-032 One sub-module, lsu_align: combinational lane extract/extend for loads and lane merge for stores.

Verification
REQ-033 Memory word 0 = 0x1234_80FF; LB addr 0x0 -> resp_rdata=0xFFFF_FFFF; LBU addr 0x1 -> 0x0000_0080; LH addr 0x2 -> 0x0000_1234; each response 2 cycles after acceptance.
REQ-034 Word 3 = 0xAABB_CCDD; SB addr 0xD wdata 0x0000_0011 -> one WE pulse, WD=0xAABB_11DD, response err=0 3 cycles after acceptance.
REQ-035 SW addr 0x6 -> resp_err=1, WE never asserted; LH addr 0x3 -> resp_err=1; LW addr 4*DM_WORDS -> resp_err=1.
REQ-036 resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, second req_valid ignored until handshake.
REQ-037 RST=1 during WR of SH addr 0x0 -> WE=0 that cycle, memory word unchanged, no response, req_ready=1 next cycle.
